// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM stage with req/ready data-memory handshake, branch resolve and MEM/WB registers
module mem_stage_ctrl #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              RegWriteEN_In,
    input  logic              Mem2RegSEL_In,
    input  logic              MemWriteEN_In,
    input  logic              Beq_In,
    input  logic              Bne_In,
    input  logic              ZeroFlag_In,
    input  logic [DATA_W-1:0] ALUResult_In,
    input  logic [DATA_W-1:0] WriteData_In,
    input  logic [REG_AW-1:0] WriteBackRegAddr_In,
    input  logic [DATA_W-1:0] PC_In,
    output logic              MemReq,
    output logic              MemWE,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemReady,
    output logic              Stall_Out,
    output logic              BranchTaken_Out,
    output logic [DATA_W-1:0] BranchTarget_Out,
    output logic              Flush_Out,
    output logic              RegWriteEN_Out,
    output logic [DATA_W-1:0] WriteBackData_Out,
    output logic [REG_AW-1:0] WriteBackRegAddr_Out,
    output logic              Error_Out
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic [DATA_W-1:0] h_addr, h_wdata;
    logic [REG_AW-1:0] h_dest;
    logic              h_we, h_load, h_regwe;
    logic              memop, misaligned, abort;
    always_comb begin
        memop            = Mem2RegSEL_In | MemWriteEN_In;
        misaligned       = memop & (ALUResult_In[1:0] != 2'b00);
        abort            = (state == WAIT) & !MemReady & (cnt == 8'(TIMEOUT));
        BranchTaken_Out  = (state == IDLE) & ((Beq_In & ZeroFlag_In) | (Bne_In & !ZeroFlag_In));
        Flush_Out        = BranchTaken_Out;
        BranchTarget_Out = PC_In;
        MemReq           = (state == IDLE) ? memop & !misaligned : !abort;
        MemWE            = (state == IDLE) ? MemWriteEN_In : h_we;
        MemAddr          = (state == IDLE) ? ALUResult_In : h_addr;
        MemWData         = (state == IDLE) ? WriteData_In : h_wdata;
        Stall_Out        = MemReq & !MemReady;
        state_nxt        = Stall_Out ? WAIT : IDLE;
        // counter starts at 1 on entry so it equals the number of WAIT cycles seen
        cnt_nxt          = !Stall_Out ? 8'd0 : (state == IDLE) ? 8'd1 : cnt + 8'd1;
    end
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state                <= IDLE;
            cnt                  <= '0;
            h_addr               <= '0;
            h_wdata              <= '0;
            h_dest               <= '0;
            h_we                 <= 1'b0;
            h_load               <= 1'b0;
            h_regwe              <= 1'b0;
            RegWriteEN_Out       <= 1'b0;
            WriteBackData_Out    <= '0;
            WriteBackRegAddr_Out <= '0;
            Error_Out            <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && Stall_Out) begin
                h_addr  <= ALUResult_In;
                h_wdata <= WriteData_In;
                h_dest  <= WriteBackRegAddr_In;
                h_we    <= MemWriteEN_In;
                h_load  <= Mem2RegSEL_In;
                h_regwe <= RegWriteEN_In;
            end
            if (Stall_Out) begin
                RegWriteEN_Out       <= 1'b0;
                WriteBackData_Out    <= '0;
                WriteBackRegAddr_Out <= '0;
            end else if (state == WAIT) begin
                // completion or abort of a held access; an abort retires nothing
                RegWriteEN_Out       <= MemReady & h_load & h_regwe;
                WriteBackData_Out    <= (MemReady & h_load) ? MemRData : '0;
                WriteBackRegAddr_Out <= h_dest;
            end else if (Mem2RegSEL_In) begin
                RegWriteEN_Out       <= RegWriteEN_In & !misaligned;
                WriteBackData_Out    <= MemRData;
                WriteBackRegAddr_Out <= WriteBackRegAddr_In;
            end else begin
                RegWriteEN_Out       <= RegWriteEN_In & !MemWriteEN_In;
                WriteBackData_Out    <= ALUResult_In;
                WriteBackRegAddr_Out <= WriteBackRegAddr_In;
            end
            if ((state == IDLE && misaligned) || abort)
                Error_Out <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl handshake, branch, error and reset behaviour
module tb_mem_stage_ctrl;
    logic        CLOCK = 1'b0, RESET = 1'b1;
    logic        RegWriteEN_In, Mem2RegSEL_In, MemWriteEN_In, Beq_In, Bne_In, ZeroFlag_In;
    logic [31:0] ALUResult_In, WriteData_In, PC_In, MemRData;
    logic [4:0]  WriteBackRegAddr_In;
    logic        MemReady;
    logic        MemReq, MemWE, Stall_Out, BranchTaken_Out, Flush_Out, RegWriteEN_Out, Error_Out;
    logic [31:0] MemAddr, MemWData, BranchTarget_Out, WriteBackData_Out;
    logic [4:0]  WriteBackRegAddr_Out;

    typedef struct {
        logic        we;
        logic [31:0] d;
        logic [4:0]  a;
        logic        full;
    } wb_t;
    wb_t q[$];
    int  errors = 0, checks = 0;

    mem_stage_ctrl #(.DATA_W(32), .REG_AW(5), .TIMEOUT(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .RegWriteEN_In(RegWriteEN_In), .Mem2RegSEL_In(Mem2RegSEL_In), .MemWriteEN_In(MemWriteEN_In),
        .Beq_In(Beq_In), .Bne_In(Bne_In), .ZeroFlag_In(ZeroFlag_In),
        .ALUResult_In(ALUResult_In), .WriteData_In(WriteData_In),
        .WriteBackRegAddr_In(WriteBackRegAddr_In), .PC_In(PC_In),
        .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
        .MemRData(MemRData), .MemReady(MemReady),
        .Stall_Out(Stall_Out), .BranchTaken_Out(BranchTaken_Out), .BranchTarget_Out(BranchTarget_Out),
        .Flush_Out(Flush_Out), .RegWriteEN_Out(RegWriteEN_Out), .WriteBackData_Out(WriteBackData_Out),
        .WriteBackRegAddr_Out(WriteBackRegAddr_Out), .Error_Out(Error_Out)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic exp_wb(input logic we, input logic [31:0] d, input logic [4:0] a, input logic full);
        wb_t e;
        e.we = we; e.d = d; e.a = a; e.full = full;
        q.push_back(e);
    endtask

    task automatic tick;
        wb_t e;
        @(posedge CLOCK);
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("wb_we", 32'(RegWriteEN_Out), 32'(e.we));
            if (e.full) begin
                chk("wb_data", WriteBackData_Out, e.d);
                chk("wb_addr", 32'(WriteBackRegAddr_Out), 32'(e.a));
            end
        end
    endtask

    task automatic drive(input logic rwe, m2r, mwe, beq, bne, z,
                         input logic [31:0] alu, wd, input logic [4:0] dest, input logic [31:0] pc);
        RegWriteEN_In = rwe; Mem2RegSEL_In = m2r; MemWriteEN_In = mwe;
        Beq_In = beq; Bne_In = bne; ZeroFlag_In = z;
        ALUResult_In = alu; WriteData_In = wd; WriteBackRegAddr_In = dest; PC_In = pc;
        #1;
    endtask

    task automatic nop;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        nop();
        MemReady = 1'b0;
        MemRData = 32'h0;
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_we", 32'(RegWriteEN_Out), 0);
        chk("rst_data", WriteBackData_Out, 0);
        chk("rst_err", 32'(Error_Out), 0);
        chk("rst_req", 32'(MemReq), 0);
        chk("rst_stall", 32'(Stall_Out), 0);

        // ALU op
        drive(1, 0, 0, 0, 0, 0, 32'h1234, 0, 5, 0);
        chk("alu_stall", 32'(Stall_Out), 0);
        chk("alu_req", 32'(MemReq), 0);
        exp_wb(1, 32'h1234, 5, 1);
        tick();

        // load with 3 stall cycles
        drive(1, 1, 0, 0, 0, 0, 32'h40, 0, 7, 0);
        chk("ld_req", 32'(MemReq), 1);
        chk("ld_we", 32'(MemWE), 0);
        chk("ld_addr0", MemAddr, 32'h40);
        chk("ld_stall0", 32'(Stall_Out), 1);
        exp_wb(0, 0, 0, 1);
        tick();
        drive(1, 1, 0, 0, 0, 0, 32'h99, 0, 9, 0);
        for (int i = 1; i <= 2; i++) begin
            chk("ld_addr_hold", MemAddr, 32'h40);
            chk("ld_stall_w", 32'(Stall_Out), 1);
            chk("ld_req_w", 32'(MemReq), 1);
            exp_wb(0, 0, 0, 1);
            tick();
        end
        MemReady = 1'b1;
        MemRData = 32'hDEADBEEF;
        #1;
        chk("ld_stall_done", 32'(Stall_Out), 0);
        chk("ld_addr_done", MemAddr, 32'h40);
        exp_wb(1, 32'hDEADBEEF, 7, 1);
        tick();

        // store, zero-wait
        drive(0, 0, 1, 0, 0, 0, 32'h10, 32'hA5A5A5A5, 2, 0);
        chk("st_req", 32'(MemReq), 1);
        chk("st_we", 32'(MemWE), 1);
        chk("st_addr", MemAddr, 32'h10);
        chk("st_wdata", MemWData, 32'hA5A5A5A5);
        chk("st_stall", 32'(Stall_Out), 0);
        exp_wb(0, 0, 0, 0);
        tick();
        MemReady = 1'b0;
        nop();
        chk("st_req_off", 32'(MemReq), 0);

        // branches
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h80);
        chk("beq_taken", 32'(BranchTaken_Out), 1);
        chk("beq_flush", 32'(Flush_Out), 1);
        chk("beq_target", BranchTarget_Out, 32'h80);
        drive(0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h80);
        chk("bne_z1", 32'(BranchTaken_Out), 0);
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h84);
        chk("bne_z0", 32'(BranchTaken_Out), 1);
        chk("bne_target", BranchTarget_Out, 32'h84);
        tick();

        // misaligned load
        drive(1, 1, 0, 0, 0, 0, 32'h42, 0, 4, 0);
        chk("mis_req", 32'(MemReq), 0);
        chk("mis_stall", 32'(Stall_Out), 0);
        exp_wb(0, 0, 0, 0);
        tick();
        chk("mis_err", 32'(Error_Out), 1);
        nop();
        tick();
        chk("mis_err_sticky", 32'(Error_Out), 1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("err_clear", 32'(Error_Out), 0);

        // timeout abort after 4 wait cycles
        drive(1, 1, 0, 0, 0, 0, 32'h80, 0, 3, 0);
        chk("to_stall0", 32'(Stall_Out), 1);
        exp_wb(0, 0, 0, 1);
        tick();
        drive(1, 1, 0, 1, 0, 1, 32'h80, 0, 3, 32'h44);
        chk("wait_br_off", 32'(BranchTaken_Out), 0);
        chk("wait_flush_off", 32'(Flush_Out), 0);
        for (int i = 1; i <= 3; i++) begin
            chk("to_stall_w", 32'(Stall_Out), 1);
            exp_wb(0, 0, 0, 1);
            tick();
        end
        chk("to_abort_stall", 32'(Stall_Out), 0);
        chk("to_abort_req", 32'(MemReq), 0);
        exp_wb(0, 0, 0, 0);
        tick();
        chk("to_err", 32'(Error_Out), 1);
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h44);
        chk("to_idle_br", 32'(BranchTaken_Out), 1);
        chk("to_idle_req", 32'(MemReq), 0);
        tick();

        // reset during second WAIT cycle, with MemReady also high
        drive(1, 1, 0, 0, 0, 0, 32'h20, 0, 6, 0);
        tick();
        tick();
        chk("rw_req", 32'(MemReq), 1);
        chk("rw_err_pre", 32'(Error_Out), 1);
        RESET = 1'b1;
        MemReady = 1'b1;
        MemRData = 32'h12345678;
        nop();
        exp_wb(0, 0, 0, 1);
        tick();
        RESET = 1'b0;
        MemReady = 1'b0;
        #1;
        chk("rw_req_off", 32'(MemReq), 0);
        chk("rw_stall", 32'(Stall_Out), 0);
        chk("rw_err", 32'(Error_Out), 0);
        chk("rw_data", WriteBackData_Out, 0);
        chk("rw_q_empty", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
